spi_cmd_decoder: RTL and testbench
==================================

// Module: spi_cmd_decoder
// PURPOSE
//  Upstream command stage of the matrix accelerator. Decodes the SPI slave's byte stream into:
//   - CSR writes: vector size, matrix size, run.
//   - Sequential writes/reads of the shared operand/result RAM.
//  Sits between the SPI slave and the array controller / RAM port mux. Read data and status return on a byte TX handshake.
// PARAMETERS
//  ADDR_SIZE       10    RAM address width; addresses wrap modulo 2**ADDR_SIZE
//  TIMEOUT_CYCLES  4096  inter-byte timeout, used only with CMD_TIMEOUT_EN
// PORTS
//  clk             in   1          system clock
//  reset           in   1          async, active-high
//  rx_valid        in   1          1-cycle pulse, rx_data valid (no backpressure)
//  rx_data         in   8          received byte
//  frame_end       in   1          1-cycle pulse on chip-select deassert
//  tx_valid        out  1          byte available for SPI shifter
//  tx_data         out  8          byte to send
//  tx_ready        in   1          shifter accepts byte when tx_valid&tx_ready
//  csr_ready       in   1          controller idle; CSR writes legal
//  vec_size_valid  out  1          1-cycle write strobe
//  vec_size_data   out  8          vector length
//  mat_size_valid  out  1          1-cycle write strobe
//  mat_size_data   out  8          matrix column count
//  run_valid       out  1          1-cycle write strobe
//  run_data        out  1          run request bit
//  mem_addr        out  ADDR_SIZE  RAM address (shared by rd/wr)
//  mem_w_en        out  1          RAM write enable, 1 cycle per byte
//  mem_w_data      out  8          RAM write data
//  mem_r_en        out  1          RAM read enable; data valid next cycle
//  mem_r_data      in   8          RAM read data
//  err             out  1          sticky error; cleared by reset or STATUS read
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; counters 0.
//  Frame: opcode byte, then payload. Opcodes:
//   0x01 VEC_SIZE d; 0x02 MAT_SIZE d; 0x03 RUN d (bit0 used)
//   0x10 MEM_WR ah al len d0..dN-1; 0x20 MEM_RD ah al len; 0x30 STATUS
//  len=0 means 256. Address = {ah,al}[ADDR_SIZE-1:0]; +1 per byte, wraps 2**ADDR_SIZE-1 -> 0.
//  FSM states: IDLE, CSR_DATA, ADDR_HI, ADDR_LO, LEN, WR_DATA, RD_ISSUE, RD_WAIT, RD_PUSH, ST_PUSH.
//  CSR path: on data byte, matching *_valid pulses the cycle after rx_valid, then IDLE.
//   If csr_ready=0, no strobe; err<=1.
//  MEM_WR: each data byte -> mem_w_en one cycle after rx_valid, then addr+1. IDLE after the len-th byte.
//  MEM_RD: RD_ISSUE asserts mem_r_en 1 cycle -> RD_WAIT captures mem_r_data -> RD_PUSH holds tx_valid until tx_ready.
//   Loops len times, then IDLE. Host clocks dummy bytes; rx bytes in RD_* are ignored.
//  STATUS: tx_data={6'b0, err, ~csr_ready}. err clears when that byte is accepted.
//  Unknown opcode: err<=1, remaining bytes ignored until frame_end.
//  frame_end in any state: next cycle IDLE; tx_valid cleared; partial command discarded.
//   Completed RAM bytes stay written.
//  Same-cycle frame_end and rx_valid: frame_end wins; byte dropped.
//  mem_w_en and mem_r_en are never high in the same cycle.
//  Async reset mid-frame: immediate return to reset values, no strobe emitted.
// CONFIGURATION
//  CMD_TIMEOUT_EN defined: counter clears on each rx_valid; counts only outside IDLE and RD_*/ST_PUSH.
//   Reaching TIMEOUT_CYCLES forces IDLE and sets err.
//  CMD_TIMEOUT_EN undefined: no counter; a stalled frame waits indefinitely for bytes or frame_end.
// STRUCTURE
//  Package spi_cmd_pkg: opcode localparams (OP_VEC_SIZE..OP_STATUS), state_t enum, STATUS bit positions.
//  One sub-module spi_tx_hold: single-entry valid/ready holding register for tx_valid/tx_data.
//  Remainder is a single FSM with address/length counters.
// TESTING
//  01 05 with csr_ready=1 -> vec_size_valid 1 cycle, vec_size_data=05, err=0.
//  03 01 with csr_ready=0 -> no run_valid; err=1. Then 30 -> tx byte 0x03; err=0 after accept.
//  10 03 FE 03 AA BB CC (ADDR_SIZE=10) -> writes 3FE=AA, 3FF=BB, 000=CC; IDLE.
//  20 00 10 02 with RAM[10]=11, RAM[11]=22, tx_ready stalled 5 cycles -> tx 11 then 22; mem_r_en twice.
//  10 00 20 04 AA then frame_end -> only 020 written; next 01 07 -> vec_size_data=07.
//  CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16: 10 00 then silence 16 cycles -> IDLE, err=1.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM state encoding and STATUS byte layout for the SPI command decoder.
package spi_cmd_pkg;

    localparam logic [7:0] OP_VEC_SIZE = 8'h01;
    localparam logic [7:0] OP_MAT_SIZE = 8'h02;
    localparam logic [7:0] OP_RUN      = 8'h03;
    localparam logic [7:0] OP_MEM_WR   = 8'h10;
    localparam logic [7:0] OP_MEM_RD   = 8'h20;
    localparam logic [7:0] OP_STATUS   = 8'h30;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_ERR_BIT  = 1;

    // DROP swallows the rest of a frame whose opcode was not recognised.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CSR_DATA = 4'd1,
        ADDR_HI  = 4'd2,
        ADDR_LO  = 4'd3,
        LEN      = 4'd4,
        WR_DATA  = 4'd5,
        RD_ISSUE = 4'd6,
        RD_WAIT  = 4'd7,
        RD_PUSH  = 4'd8,
        ST_PUSH  = 4'd9,
        DROP     = 4'd10
    } state_t;

    function automatic logic [7:0] status_byte(input logic err, input logic csr_ready);
        logic [7:0] b;
        b = 8'h00;
        b[STATUS_ERR_BIT]  = err;
        b[STATUS_BUSY_BIT] = ~csr_ready;
        return b;
    endfunction

endpackage

// File: rtl/spi_tx_hold.sv
// Single-entry holding register between the command decoder and the SPI shifter.
module spi_tx_hold (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data
);

    // Handshake: tx_valid stays high and tx_data stable until the cycle where
    // tx_valid && tx_ready, which is the transfer; the producer only pushes
    // into an empty entry, and flush (frame end) drops the entry unconditionally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (flush) begin
            tx_valid <= 1'b0;
        end else if (push) begin
            tx_valid <= 1'b1;
            tx_data  <= push_data;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI command frames into CSR strobes and sequential RAM accesses.
// Optional inter-byte timeout is compiled in with `define CMD_TIMEOUT_EN.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_SIZE      = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 frame_end,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    input  logic                 csr_ready,
    output logic                 vec_size_valid,
    output logic [7:0]           vec_size_data,
    output logic                 mat_size_valid,
    output logic [7:0]           mat_size_data,
    output logic                 run_valid,
    output logic                 run_data,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_w_en,
    output logic [7:0]           mem_w_data,
    output logic                 mem_r_en,
    input  logic [7:0]           mem_r_data,
    output logic                 err,
    output logic [3:0]           dbg_state
);

    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);

    state_t                state;
    logic [7:0]            op_q;
    logic                  is_rd;
    logic [7:0]            addr_hi;
    logic [ADDR_SIZE-1:0]  addr_q;
    logic [8:0]            rem;
    logic [8:0]            len_byte;
    logic                  timeout;
    logic                  tx_push;
    logic [7:0]            tx_push_data;

    assign dbg_state = state;
    assign len_byte  = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};

    // STATUS answers immediately from the opcode cycle; read data is pushed from RD_WAIT.
    always_comb begin
        tx_push      = 1'b0;
        tx_push_data = mem_r_data;
        if (!frame_end) begin
            if (state == RD_WAIT) begin
                tx_push = 1'b1;
            end else if (state == IDLE && rx_valid && rx_data == OP_STATUS) begin
                tx_push      = 1'b1;
                tx_push_data = status_byte(err, csr_ready);
            end
        end
    end

    spi_tx_hold u_tx_hold (
        .clk       (clk),
        .reset     (reset),
        .flush     (frame_end),
        .push      (tx_push),
        .push_data (tx_push_data),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data)
    );

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;
    logic            to_active;

    // Read and STATUS phases wait on the host's TX clocking, so they never time out.
    assign to_active = !(state inside {IDLE, RD_ISSUE, RD_WAIT, RD_PUSH, ST_PUSH});
    assign timeout   = to_active && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (rx_valid || !to_active || frame_end || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    // Without the timeout a stalled frame simply waits; TIMEOUT_CYCLES has no effect.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            op_q           <= 8'h00;
            is_rd          <= 1'b0;
            addr_hi        <= 8'h00;
            addr_q         <= '0;
            rem            <= 9'd0;
            err            <= 1'b0;
            vec_size_valid <= 1'b0;
            vec_size_data  <= 8'h00;
            mat_size_valid <= 1'b0;
            mat_size_data  <= 8'h00;
            run_valid      <= 1'b0;
            run_data       <= 1'b0;
            mem_addr       <= '0;
            mem_w_en       <= 1'b0;
            mem_w_data     <= 8'h00;
            mem_r_en       <= 1'b0;
        end else begin
            vec_size_valid <= 1'b0;
            mat_size_valid <= 1'b0;
            run_valid      <= 1'b0;
            mem_w_en       <= 1'b0;
            mem_r_en       <= 1'b0;

            if (frame_end) begin
                state <= IDLE;
            end else if (timeout) begin
                state <= IDLE;
                err   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_valid) begin
                            case (rx_data)
                                OP_VEC_SIZE, OP_MAT_SIZE, OP_RUN: begin
                                    op_q  <= rx_data;
                                    state <= CSR_DATA;
                                end
                                OP_MEM_WR: begin
                                    is_rd <= 1'b0;
                                    state <= ADDR_HI;
                                end
                                OP_MEM_RD: begin
                                    is_rd <= 1'b1;
                                    state <= ADDR_HI;
                                end
                                OP_STATUS: state <= ST_PUSH;
                                default: begin
                                    err   <= 1'b1;
                                    state <= DROP;
                                end
                            endcase
                        end
                    end
                    CSR_DATA: begin
                        if (rx_valid) begin
                            state <= IDLE;
                            if (!csr_ready) begin
                                err <= 1'b1;
                            end else if (op_q == OP_VEC_SIZE) begin
                                vec_size_valid <= 1'b1;
                                vec_size_data  <= rx_data;
                            end else if (op_q == OP_MAT_SIZE) begin
                                mat_size_valid <= 1'b1;
                                mat_size_data  <= rx_data;
                            end else begin
                                run_valid <= 1'b1;
                                run_data  <= rx_data[0];
                            end
                        end
                    end
                    ADDR_HI: begin
                        if (rx_valid) begin
                            addr_hi <= rx_data;
                            state   <= ADDR_LO;
                        end
                    end
                    ADDR_LO: begin
                        if (rx_valid) begin
                            addr_q <= ADDR_SIZE'({addr_hi, rx_data});
                            state  <= LEN;
                        end
                    end
                    LEN: begin
                        if (rx_valid) begin
                            rem <= len_byte;
                            if (is_rd) begin
                                // mem_r_en is visible during RD_ISSUE, so data is ready in RD_WAIT.
                                mem_r_en <= 1'b1;
                                mem_addr <= addr_q;
                                addr_q   <= addr_q + ADDR_ONE;
                                state    <= RD_ISSUE;
                            end else begin
                                state <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (rx_valid) begin
                            mem_w_en   <= 1'b1;
                            mem_w_data <= rx_data;
                            mem_addr   <= addr_q;
                            addr_q     <= addr_q + ADDR_ONE;
                            rem        <= rem - 9'd1;
                            if (rem == 9'd1) state <= IDLE;
                        end
                    end
                    RD_ISSUE: state <= RD_WAIT;
                    RD_WAIT:  state <= RD_PUSH;
                    RD_PUSH: begin
                        if (tx_valid && tx_ready) begin
                            rem <= rem - 9'd1;
                            if (rem == 9'd1) begin
                                state <= IDLE;
                            end else begin
                                mem_r_en <= 1'b1;
                                mem_addr <= addr_q;
                                addr_q   <= addr_q + ADDR_ONE;
                                state    <= RD_ISSUE;
                            end
                        end
                    end
                    ST_PUSH: begin
                        if (tx_valid && tx_ready) begin
                            err   <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    DROP:    state <= DROP;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: CSR vector table plus hand-written frame sequences.
module tb_spi_cmd_decoder;
    import spi_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        frame_end;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        csr_ready;
    logic        vec_size_valid;
    logic [7:0]  vec_size_data;
    logic        mat_size_valid;
    logic [7:0]  mat_size_data;
    logic        run_valid;
    logic        run_data;
    logic [9:0]  mem_addr;
    logic        mem_w_en;
    logic [7:0]  mem_w_data;
    logic        mem_r_en;
    logic [7:0]  mem_r_data;
    logic        err;
    logic [3:0]  dbg_state;

    spi_cmd_decoder #(.ADDR_SIZE(10), .TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .frame_end      (frame_end),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .csr_ready      (csr_ready),
        .vec_size_valid (vec_size_valid),
        .vec_size_data  (vec_size_data),
        .mat_size_valid (mat_size_valid),
        .mat_size_data  (mat_size_data),
        .run_valid      (run_valid),
        .run_data       (run_data),
        .mem_addr       (mem_addr),
        .mem_w_en       (mem_w_en),
        .mem_w_data     (mem_w_data),
        .mem_r_en       (mem_r_en),
        .mem_r_data     (mem_r_data),
        .err            (err),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // RAM model: synchronous read, data valid the cycle after mem_r_en
    logic [7:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_w_en) ram[mem_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= ram[mem_addr];
    end

    // observed traffic
    logic [17:0] got_wr[$];
    logic [7:0]  got_tx[$];
    int vec_cnt = 0, mat_cnt = 0, run_cnt = 0, rd_cnt = 0, overlap = 0;
    logic [7:0] vec_last = 8'h00, mat_last = 8'h00;
    logic       run_last = 1'b0;

    always @(negedge clk) begin
        if (mem_w_en) got_wr.push_back({mem_addr, mem_w_data});
        if (tx_valid && tx_ready) got_tx.push_back(tx_data);
        if (mem_r_en) rd_cnt <= rd_cnt + 1;
        if (mem_r_en && mem_w_en) overlap <= overlap + 1;
        if (vec_size_valid) begin vec_cnt <= vec_cnt + 1; vec_last <= vec_size_data; end
        if (mat_size_valid) begin mat_cnt <= mat_cnt + 1; mat_last <= mat_size_data; end
        if (run_valid) begin run_cnt <= run_cnt + 1; run_last <= run_data; end
    end

    // scoreboard
    logic [17:0] exp_wr[$];
    logic [7:0]  exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_wr();
        int n;
        check("wr_count", got_wr.size(), exp_wr.size());
        n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) check("wr_addr_data", got_wr[i], exp_wr[i]);
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic check_tx();
        int n;
        check("tx_count", got_tx.size(), exp_q.size());
        n = (got_tx.size() < exp_q.size()) ? got_tx.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("tx_byte", got_tx[i], exp_q[i]);
        got_tx.delete();
        exp_q.delete();
    endtask

    // driver tasks
    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_tx(input int n);
        int budget;
        budget = 200;
        while (got_tx.size() < n && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check("tx_wait_timeout", got_tx.size(), n);
    endtask

    task automatic status_read(input logic [7:0] exp_byte);
        exp_q.push_back(exp_byte);
        send(OP_STATUS);
        wait_tx(1);
        @(posedge clk); #1;
        check_tx();
        check("status_err_cleared", err, 1'b0);
        check("status_state_idle", dbg_state, IDLE);
        end_frame();
    endtask

    typedef struct {
        logic [7:0] op;
        logic [7:0] data;
        logic       rdy;
        logic [2:0] exp_strb;   // {run, mat, vec}
        logic [7:0] exp_data;
        logic       exp_err;
    } csr_vec_t;

    csr_vec_t tbl[6];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, m0, r0, rc0;

        tbl[0] = '{op: 8'h01, data: 8'h05, rdy: 1'b1, exp_strb: 3'b001, exp_data: 8'h05, exp_err: 1'b0};
        tbl[1] = '{op: 8'h02, data: 8'h0A, rdy: 1'b1, exp_strb: 3'b010, exp_data: 8'h0A, exp_err: 1'b0};
        tbl[2] = '{op: 8'h03, data: 8'h01, rdy: 1'b1, exp_strb: 3'b100, exp_data: 8'h01, exp_err: 1'b0};
        tbl[3] = '{op: 8'h03, data: 8'hFE, rdy: 1'b1, exp_strb: 3'b100, exp_data: 8'h00, exp_err: 1'b0};
        tbl[4] = '{op: 8'h03, data: 8'h01, rdy: 1'b0, exp_strb: 3'b000, exp_data: 8'h00, exp_err: 1'b1};
        tbl[5] = '{op: 8'h01, data: 8'h33, rdy: 1'b0, exp_strb: 3'b000, exp_data: 8'h00, exp_err: 1'b1};

        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        frame_end = 1'b0;
        tx_ready  = 1'b1;
        csr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", dbg_state, IDLE);
        check("rst_err", err, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_outputs", {vec_size_valid, mat_size_valid, run_valid, mem_w_en, mem_r_en}, 5'b0);
        check("rst_addr", mem_addr, 10'h000);
        reset = 1'b0;
        @(posedge clk); #1;

        // CSR vectors
        for (int i = 0; i < 6; i++) begin
            csr_ready = tbl[i].rdy;
            v0 = vec_cnt; m0 = mat_cnt; r0 = run_cnt;
            send(tbl[i].op);
            send(tbl[i].data);
            check("csr_vec_strobes", vec_cnt - v0, tbl[i].exp_strb[0]);
            check("csr_mat_strobes", mat_cnt - m0, tbl[i].exp_strb[1]);
            check("csr_run_strobes", run_cnt - r0, tbl[i].exp_strb[2]);
            if (tbl[i].exp_strb[0]) check("csr_vec_data", vec_last, tbl[i].exp_data);
            if (tbl[i].exp_strb[1]) check("csr_mat_data", mat_last, tbl[i].exp_data);
            if (tbl[i].exp_strb[2]) check("csr_run_data", run_last, tbl[i].exp_data[0]);
            check("csr_err", err, tbl[i].exp_err);
            check("csr_state_idle", dbg_state, IDLE);
            end_frame();
            if (tbl[i].exp_err) status_read({6'b0, 1'b1, ~tbl[i].rdy});
        end
        csr_ready = 1'b1;

        // STATUS with clean err, both csr_ready levels
        status_read(8'h00);
        csr_ready = 1'b0;
        status_read(8'h01);
        csr_ready = 1'b1;

        // unknown opcode swallows the rest of the frame
        v0 = vec_cnt;
        send(8'h55); send(8'h01); send(8'h07);
        check("unk_no_strobe", vec_cnt - v0, 0);
        check("unk_err", err, 1'b1);
        check("unk_state_drop", dbg_state, DROP);
        end_frame();
        check("unk_frame_end_idle", dbg_state, IDLE);
        status_read(8'h02);

        // MEM_WR wrapping past the top of the address space
        send(8'h10); send(8'h03); send(8'hFE); send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC);
        exp_wr.push_back({10'h3FE, 8'hAA});
        exp_wr.push_back({10'h3FF, 8'hBB});
        exp_wr.push_back({10'h000, 8'hCC});
        check_wr();
        check("wr_wrap_idle", dbg_state, IDLE);
        end_frame();

        // load read operands
        send(8'h10); send(8'h00); send(8'h10); send(8'h02);
        send(8'h11); send(8'h22);
        exp_wr.push_back({10'h010, 8'h11});
        exp_wr.push_back({10'h011, 8'h22});
        check_wr();
        end_frame();

        // MEM_RD with the shifter stalled, dummy host byte ignored
        tx_ready = 1'b0;
        rc0 = rd_cnt;
        send(8'h20); send(8'h00); send(8'h10); send(8'h02);
        repeat (5) @(posedge clk);
        #1;
        check("rd_stall_tx_valid", tx_valid, 1'b1);
        check("rd_stall_tx_data", tx_data, 8'h11);
        check("rd_stall_one_issue", rd_cnt - rc0, 1);
        send(8'hFF);
        check("rd_dummy_no_write", got_wr.size(), 0);
        tx_ready = 1'b1;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        wait_tx(2);
        repeat (2) @(posedge clk);
        #1;
        check_tx();
        check("rd_issue_count", rd_cnt - rc0, 2);
        check("rd_done_idle", dbg_state, IDLE);
        end_frame();

        // frame aborted mid MEM_WR, then a clean CSR write
        send(8'h10); send(8'h00); send(8'h20); send(8'h04); send(8'hAA);
        end_frame();
        exp_wr.push_back({10'h020, 8'hAA});
        check_wr();
        check("abort_idle", dbg_state, IDLE);
        v0 = vec_cnt;
        send(8'h01); send(8'h07);
        check("abort_next_vec_strobe", vec_cnt - v0, 1);
        check("abort_next_vec_data", vec_last, 8'h07);
        end_frame();

        // frame_end and rx_valid in the same cycle: byte dropped
        v0 = vec_cnt;
        send(8'h01);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h05; frame_end = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; frame_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("same_cycle_no_strobe", vec_cnt - v0, 0);
        check("same_cycle_idle", dbg_state, IDLE);
        m0 = mat_cnt;
        send(8'h02); send(8'h09);
        check("same_cycle_next_mat", mat_cnt - m0, 1);
        check("same_cycle_next_data", mat_last, 8'h09);
        end_frame();

        // asynchronous reset mid-frame
        csr_ready = 1'b0;
        send(8'h01); send(8'h05);
        check("pre_reset_err", err, 1'b1);
        end_frame();
        csr_ready = 1'b1;
        send(8'h10); send(8'h00); send(8'h20);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_err", err, 1'b0);
        check("async_rst_state", dbg_state, IDLE);
        check("async_rst_tx_valid", tx_valid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        v0 = vec_cnt;
        send(8'h01); send(8'h08);
        check("post_rst_vec_strobe", vec_cnt - v0, 1);
        check("post_rst_vec_data", vec_last, 8'h08);
        check("post_rst_no_write", got_wr.size(), 0);
        end_frame();

`ifdef CMD_TIMEOUT_EN
        send(8'h10); send(8'h00);
        repeat (8) @(posedge clk);
        #1;
        check("timeout_not_yet", dbg_state, ADDR_LO);
        repeat (10) @(posedge clk);
        #1;
        check("timeout_idle", dbg_state, IDLE);
        check("timeout_err", err, 1'b1);
        end_frame();
        status_read(8'h02);
`endif

        check("rd_wr_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
